// File: rtl/rotary_value_ctrl.sv
// rotary_value_ctrl: turns quadrature step/dir/error pulses into a bounded value
// with velocity acceleration. Steps closer than p_FAST_TICKS cycles in the same
// direction move the value by p_FAST_STEP; otherwise by 1. Changes are published
// over valid/ready. Optional macro RVC_WRAP_EN: out-of-range results wrap modulo
// (p_MAX-p_MIN+1) instead of clamping.
module rotary_value_ctrl #(
  parameter int p_WIDTH      = 8,
  parameter int p_MIN        = 0,
  parameter int p_MAX        = 255,
  parameter int p_INIT       = 0,
  parameter int p_FAST_TICKS = 100000,
  parameter int p_FAST_STEP  = 4,
  parameter int p_ERR_WIDTH  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_step,
  input  logic                   i_cw,
  input  logic                   i_err,
  input  logic                   i_clear,
  output logic [p_WIDTH-1:0]     ov_value,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [p_ERR_WIDTH-1:0] ov_err_cnt,
  output logic                   o_fast
);

  localparam int SW = p_WIDTH + 2;
  localparam int GW = $clog2(p_FAST_TICKS + 1);

  localparam logic signed [SW-1:0] MIN_S   = SW'(p_MIN);
  localparam logic signed [SW-1:0] MAX_S   = SW'(p_MAX);
  localparam logic signed [SW-1:0] RANGE_S = SW'(p_MAX - p_MIN + 1);
  localparam logic signed [SW-1:0] FSTEP_S = SW'(p_FAST_STEP);
  localparam logic signed [SW-1:0] ONE_S   = SW'(1);
  localparam logic [GW-1:0]        TICKS   = GW'(p_FAST_TICKS);
  localparam logic [p_WIDTH-1:0]   INIT_V  = p_WIDTH'(p_INIT);

  typedef enum logic {S_SLOW = 1'b0, S_FAST = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [p_WIDTH-1:0]     value_q, value_d;
  logic                   valid_q, valid_d;
  logic [p_ERR_WIDTH-1:0] err_q, err_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   dir_q, dir_d;

  logic                   fast_step;
  logic signed [SW-1:0]   cur, delta, sum, res;
  logic [p_WIDTH-1:0]     new_val;

  // Step arithmetic: signed sum with two guard bits, then clamp or wrap.
  always_comb begin
    // gap_q never exceeds TICKS, so "not saturated" means gap < p_FAST_TICKS
    fast_step = (gap_q != TICKS) && (i_cw == dir_q);
    delta     = fast_step ? FSTEP_S : ONE_S;
    cur       = $signed({2'b00, value_q});
    sum       = i_cw ? (cur + delta) : (cur - delta);
    res       = sum;
`ifdef RVC_WRAP_EN
    if (sum > MAX_S)      res = sum - RANGE_S;
    else if (sum < MIN_S) res = sum + RANGE_S;
`else
    if (sum > MAX_S)      res = MAX_S;
    else if (sum < MIN_S) res = MIN_S;
`endif
    new_val = res[p_WIDTH-1:0];
  end

  // Next state: gap timer, SLOW/FAST, value, handshake, error count; clear wins.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    valid_d = valid_q;
    err_d   = err_q;
    dir_d   = dir_q;
    gap_d   = (gap_q == TICKS) ? gap_q : gap_q + 1'b1;

    if (valid_q && i_ready) valid_d = 1'b0;

    if (i_step) begin
      gap_d   = '0;
      dir_d   = i_cw;
      state_d = fast_step ? S_FAST : S_SLOW;
      value_d = new_val;
      // a transfer in the same cycle is overridden: the new value stays pending
      if (new_val != value_q) valid_d = 1'b1;
    end else if (gap_d == TICKS) begin
      state_d = S_SLOW;
    end

    if (i_err && (err_q != '1)) err_d = err_q + 1'b1;

    if (i_clear) begin
      state_d = S_SLOW;
      value_d = INIT_V;
      err_d   = '0;
      gap_d   = TICKS;
      dir_d   = 1'b1;
      valid_d = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_SLOW;
      value_q <= INIT_V;
      valid_q <= 1'b0;
      err_q   <= '0;
      gap_q   <= TICKS;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      dir_q   <= dir_d;
    end
  end

  assign ov_value   = value_q;
  assign o_valid    = valid_q;
  assign ov_err_cnt = err_q;
  assign o_fast     = (state_q == S_FAST);

endmodule

// File: tb/tb_rotary_value_ctrl.sv
// Testbench for rotary_value_ctrl: directed scenarios plus random traffic,
// checked every cycle against a timestamp-based reference model.
module tb_rotary_value_ctrl;

  localparam int W = 4, MN = 0, MX = 9, INIT = 5, TICKS = 8, FSTEP = 3, EW = 4;

  logic          CLK = 1'b0;
  logic          RST, i_step, i_cw, i_err, i_clear, i_ready;
  logic [W-1:0]  ov_value;
  logic          o_valid, o_fast;
  logic [EW-1:0] ov_err_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_val, m_err, m_valid, m_fast, m_dir, edge_n, last_n, m_sat;

  rotary_value_ctrl #(
    .p_WIDTH(W), .p_MIN(MN), .p_MAX(MX), .p_INIT(INIT),
    .p_FAST_TICKS(TICKS), .p_FAST_STEP(FSTEP), .p_ERR_WIDTH(EW)
  ) dut (
    .CLK(CLK), .RST(RST), .i_step(i_step), .i_cw(i_cw), .i_err(i_err),
    .i_clear(i_clear), .ov_value(ov_value), .o_valid(o_valid),
    .i_ready(i_ready), .ov_err_cnt(ov_err_cnt), .o_fast(o_fast)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_val = INIT; m_err = 0; m_valid = 0; m_fast = 0; m_dir = 1; m_sat = 1;
    edge_n = 0; last_n = 0;
  endtask

  // One clock edge of the reference, from the inputs as currently driven.
  task automatic model_edge();
    int nv, d, changed;
    bit f;
    edge_n++;
    if (i_clear) begin
      m_val = INIT; m_err = 0; m_fast = 0; m_sat = 1; m_dir = 1; m_valid = 1;
    end else begin
      changed = 0;
      if (i_step) begin
        f  = !m_sat && ((edge_n - last_n - 1) < TICKS) && (int'(i_cw) == m_dir);
        d  = f ? FSTEP : 1;
        nv = i_cw ? m_val + d : m_val - d;
`ifdef RVC_WRAP_EN
        if (nv > MX) nv = nv - (MX - MN + 1);
        if (nv < MN) nv = nv + (MX - MN + 1);
`else
        if (nv > MX) nv = MX;
        if (nv < MN) nv = MN;
`endif
        changed = (nv != m_val);
        m_val = nv; m_fast = f; m_dir = i_cw; last_n = edge_n; m_sat = 0;
      end else if (!m_sat && (edge_n - last_n) >= TICKS) begin
        m_fast = 0;
      end
      if (i_err && m_err < (1 << EW) - 1) m_err++;
      if (changed) m_valid = 1;
      else if (m_valid && i_ready) m_valid = 0;
    end
  endtask

  task automatic check_all();
    chk("value", ov_value, m_val);
    chk("valid", o_valid, m_valid);
    chk("fast", o_fast, m_fast);
    chk("err_cnt", ov_err_cnt, m_err);
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic drive(input bit s, input bit c, input bit e, input bit cl, input bit r);
    i_step = s; i_cw = c; i_err = e; i_clear = cl; i_ready = r;
    tick();
    i_step = 0; i_err = 0; i_clear = 0;
  endtask

  task automatic idle(input int n, input bit r);
    for (int k = 0; k < n; k++) drive(0, i_cw, 0, 0, r);
  endtask

  initial begin
    bit pdir;
    RST = 1; i_step = 0; i_cw = 1; i_err = 0; i_clear = 0; i_ready = 0;
    model_reset();
    #1;
    chk("rst_value", ov_value, INIT);
    chk("rst_valid", o_valid, 0);
    chk("rst_fast", o_fast, 0);
    chk("rst_err", ov_err_cnt, 0);
    @(negedge CLK); RST = 0;
    @(posedge CLK); #1;

    // idle after reset
    idle(10, 0);
    chk("idle_value", ov_value, 5);
    chk("idle_valid", o_valid, 0);

    // slow cw steps 20 cycles apart
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 0, 1);
      chk("slow_value", ov_value, 6 + k);
      chk("slow_valid", o_valid, 1);
      chk("slow_fast", o_fast, 0);
      idle(19, 1);
    end

    // back to 5, then cw steps 2 cycles apart
    drive(0, 1, 0, 1, 1);
    chk("clr_value", ov_value, 5);
    idle(10, 1);
    drive(1, 1, 0, 0, 1); chk("acc1_value", ov_value, 6); chk("acc1_fast", o_fast, 0);
    idle(1, 1);
    drive(1, 1, 0, 0, 1); chk("acc2_value", ov_value, 9); chk("acc2_fast", o_fast, 1);
    idle(1, 1);
    drive(1, 1, 0, 0, 1);
`ifdef RVC_WRAP_EN
    chk("acc3_value", ov_value, 2); chk("acc3_valid", o_valid, 1);
`else
    chk("acc3_value", ov_value, 9); chk("acc3_valid", o_valid, 0);
`endif
    idle(1, 1);
    // reversal while FAST drops back to unit steps
    drive(1, 0, 0, 0, 1);
    chk("rev_fast", o_fast, 0);
    idle(1, 1);
    drive(1, 1, 0, 0, 1); idle(1, 1);
    drive(1, 1, 0, 0, 1);
    chk("refast", o_fast, 1);
    idle(TICKS + 2, 1);
    chk("timeout_fast", o_fast, 0);

    // consumer stalled across two changes
    drive(1, 0, 0, 0, 0); idle(19, 0);
    drive(1, 0, 0, 0, 0);
    chk("stall_valid", o_valid, 1);
    idle(5, 0);
    drive(0, 1, 0, 0, 1);
    chk("accept_valid", o_valid, 0);

    // error saturation, then clear colliding with step/err/ready
    for (int k = 0; k < 20; k++) drive(0, 1, 1, 0, 1);
    chk("err_sat", ov_err_cnt, 15);
    drive(1, 1, 1, 1, 1);
    chk("clr_step_value", ov_value, 5);
    chk("clr_step_err", ov_err_cnt, 0);
    chk("clr_step_valid", o_valid, 1);

    // asynchronous reset in the middle of activity
    drive(1, 0, 1, 0, 0); idle(1, 0);
    drive(1, 0, 1, 0, 0);
    #2 RST = 1;
    #1;
    model_reset();
    check_all();
    @(negedge CLK); RST = 0;
    @(posedge CLK); #1;

    // random traffic
    pdir = 1;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 24) == 0) idle(TICKS + $urandom_range(0, 4), $urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) pdir = ~pdir;
      drive($urandom_range(0, 2) == 0, pdir, $urandom_range(0, 7) == 0,
            $urandom_range(0, 59) == 0, $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
